button_debounce: RTL and testbench

Debounced pushbutton input stage for the iCEstick designs: synchronizes a raw, bouncing button/PMOD input to `clk`, filters it, and emits a clean level plus single-cycle press, release and long-press strobes. It is the input counterpart of the LED output drivers. Typical use is stepping or reversing the LED rotation from a button instead of a free-running timer.

---
 rtl/icestick_pkg.sv | 8 +
 rtl/sync_2ff.sv | 30 +++
 rtl/button_debounce.sv | 97 +++++++++
 tb/tb_button_debounce.sv | 120 ++++++++++++
 4 files changed

// File: rtl/icestick_pkg.sv
// Board-level constants shared by the iCEstick designs.
// Peripheral defaults are derived from these so that retargeting the clock only touches this file.
package icestick_pkg;

  localparam int CLK_HZ    = 12_000_000;
  localparam int MS_CYCLES = CLK_HZ / 1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// It resets to 0 and is meant for reuse by the button, UART RX and PMOD input stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Debounced pushbutton input: synchronize, filter, and emit a clean level plus press/release/long-press strobes.
// The release strobe port is named release_pulse because `release` is a reserved word in SystemVerilog.
module button_debounce
  import icestick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10 * MS_CYCLES,
  parameter int LONG_CYCLES     = 1000 * MS_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic          btn_norm;
  logic          btn_sync;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          accept;

  assign btn_norm = btn_in ^ ACTIVE_LOW;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_norm),
    .q   (btn_sync)
  );

  always_comb begin
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    accept     = 1'b0;

    if (btn_sync == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      accept    = 1'b1;
      db_cnt_d  = '0;
      level_d   = btn_sync;
      press_d   = btn_sync;
      release_d = ~btn_sync;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end

    // An accepted release on the same edge as the long-press threshold wins over it.
    if (!level_q || accept) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q < HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      long_d     = (hold_cnt_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign btn_level     = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, active-low button.
// Expected output vectors {btn_level, press, release, long_press} go through a scoreboard queue.
module tb_button_debounce;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic btn_in = 1'b1;
  logic btn_level, press, release_pulse, long_press;

  logic [3:0] exp_q[$];
  int         total   = 0;
  int         bad     = 0;
  int         step_no = 0;
  string      scen    = "reset";

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (10),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  task automatic checkOutput();
    logic [3:0] want;
    logic [3:0] got;
    want = exp_q.pop_front();
    got  = {btn_level, press, release_pulse, long_press};
    total++;
    assert (got === want)
      else begin
        bad++;
        $error("[TB] FAIL %s step %0d got=%b want=%b", scen, step_no, got, want);
      end
  endtask

  // One clock: drive inputs, queue the expectation for after the edge, then check just past the edge.
  task automatic applyStimulus(input logic b, input logic r, input logic [3:0] want);
    btn_in = b;
    rst    = r;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    step_no++;
    checkOutput();
  endtask

  task automatic runSteps(input int n, input logic b, input logic [3:0] want);
    for (int i = 0; i < n; i++) applyStimulus(b, 1'b0, want);
  endtask

  initial begin
    scen = "reset";
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'b0000);

    scen = "idle"; step_no = 0;
    runSteps(20, 1'b1, 4'b0000);

    scen = "clean_press"; step_no = 0;
    runSteps(5, 1'b0, 4'b0000);
    runSteps(1, 1'b0, 4'b1100);
    runSteps(1, 1'b0, 4'b1000);

    scen = "long_hold";
    runSteps(8, 1'b0, 4'b1000);
    runSteps(1, 1'b0, 4'b1001);
    runSteps(30, 1'b0, 4'b1000);

    scen = "release_after_long"; step_no = 0;
    runSteps(5, 1'b1, 4'b1000);
    runSteps(1, 1'b1, 4'b0010);
    runSteps(4, 1'b1, 4'b0000);

    scen = "bounce"; step_no = 0;
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    runSteps(5, 1'b0, 4'b0000);
    // Raw release is already sampled on the edge that accepts the press.
    runSteps(1, 1'b1, 4'b1100);

    scen = "short_hold";
    runSteps(4, 1'b1, 4'b1000);
    runSteps(1, 1'b1, 4'b0010);
    runSteps(15, 1'b1, 4'b0000);

    scen = "release_wins"; step_no = 0;
    runSteps(5, 1'b0, 4'b0000);
    runSteps(1, 1'b0, 4'b1100);
    runSteps(4, 1'b0, 4'b1000);
    runSteps(5, 1'b1, 4'b1000);
    runSteps(1, 1'b1, 4'b0010);
    runSteps(11, 1'b1, 4'b0000);

    scen = "mid_hold_reset"; step_no = 0;
    runSteps(5, 1'b0, 4'b0000);
    runSteps(1, 1'b0, 4'b1100);
    runSteps(5, 1'b0, 4'b1000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    runSteps(5, 1'b0, 4'b0000);
    runSteps(1, 1'b0, 4'b1100);
    runSteps(9, 1'b0, 4'b1000);
    runSteps(1, 1'b0, 4'b1001);
    runSteps(5, 1'b0, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
